// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and types for the two-port memory arbiter
// Holds memory stage/op codes, FSM state encoding and the port identifier type.
package mem_arb_pkg;
    localparam logic [2:0] STATE_NONE   = 3'd0;
    localparam logic [2:0] STATE_MEMORY = 3'd4;
    localparam logic [1:0] MEM_READ     = 2'b00;
    localparam logic [1:0] MEM_WRITE    = 2'b01;
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_RESP      = 2'd2;
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between requesters A and B
// Ports: a_req/b_req requests in; last (MEM_ARB_RR_EN only) previous grant in;
//        grant winning port out; valid high when any request is present.
// Macro MEM_ARB_RR_EN: round-robin on conflict; otherwise B has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic  a_req,
    input  logic  b_req,
`ifdef MEM_ARB_RR_EN
    input  port_t last,
`endif
    output port_t grant,
    output logic  valid
);
    always_comb valid = a_req | b_req;
`ifdef MEM_ARB_RR_EN
    always_comb grant = (a_req && b_req) ? ((last == PORT_B) ? PORT_A : PORT_B)
                                         : (b_req ? PORT_B : PORT_A);
`else
    always_comb grant = b_req ? PORT_B : PORT_A;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch port A and load-store port B onto one data memory
// Ports: clk, rst (sync, active-high); a_/b_ req, we, addr, wdata in;
//        a_/b_ rdata, done out; mem_state, mem_op, mem_addr, mem_wdata out;
//        mem_rdata in (registered by memory at the access edge); busy out.
// Macro MEM_ARB_RR_EN: round-robin arbitration; undefined gives B fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_done,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_done,
    output logic [2:0]        mem_state,
    output logic [1:0]        mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    logic [1:0]        state_q, state_d;
    port_t             win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    port_t             grant;
    logic              req_any;
    logic              issue, resp;
`ifdef MEM_ARB_RR_EN
    port_t             last_q, last_d;
`endif

    mem_arb_pick u_pick (
        .a_req (a_req),
        .b_req (b_req),
`ifdef MEM_ARB_RR_EN
        .last  (last_q),
`endif
        .grant (grant),
        .valid (req_any)
    );

    always_comb begin
        issue     = state_q == ST_ISSUE;
        resp      = state_q == ST_RESP;
        state_d   = ST_IDLE;
        win_d     = win_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d    = last_q;
`endif
        if (state_q == ST_IDLE) begin
            if (req_any) begin
                state_d = ST_ISSUE;
                win_d   = grant;
                we_d    = (grant == PORT_B) ? b_we : a_we;
                addr_d  = (grant == PORT_B) ? b_addr : a_addr;
                wdata_d = (grant == PORT_B) ? b_wdata : a_wdata;
`ifdef MEM_ARB_RR_EN
                last_d  = grant;
`endif
            end
        end else if (issue) begin
            state_d = ST_RESP;
        end else if (resp && !we_q) begin
            a_rdata_d = (win_q == PORT_A) ? mem_rdata : a_rdata_q;
            b_rdata_d = (win_q == PORT_B) ? mem_rdata : b_rdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            win_q     <= PORT_A;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q    <= PORT_B;
`endif
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    // Memory data arrives in RESP, so the response is forwarded straight from
    // mem_rdata; a reset landing on RESP suppresses the pending completion.
    always_comb begin
        a_done    = resp && (win_q == PORT_A) && !rst;
        b_done    = resp && (win_q == PORT_B) && !rst;
        a_rdata   = (a_done && !we_q) ? mem_rdata : a_rdata_q;
        b_rdata   = (b_done && !we_q) ? mem_rdata : b_rdata_q;
        mem_state = issue ? STATE_MEMORY : STATE_NONE;
        mem_op    = (issue && we_q) ? MEM_WRITE : MEM_READ;
        mem_addr  = issue ? addr_q : '0;
        mem_wdata = issue ? wdata_q : '0;
        busy      = state_q != ST_IDLE;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction schedule model
module tb_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [7:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic [7:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;
    logic       a_done, b_done, busy;
    logic [2:0] mem_state;
    logic [1:0] mem_op;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_rdata   (a_rdata),
        .a_done    (a_done),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_rdata   (b_rdata),
        .b_done    (b_done),
        .mem_state (mem_state),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk)
        if (mem_state == 3'd4) begin
            if (mem_op == 2'b01) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ref_mem [256];
    int         cyc = 0;
    int         tg = -10;
    bit         act = 1'b0, w_b = 1'b0, w_we = 1'b0, last_b = 1'b1;
    bit         seen_a = 1'b0, seen_b = 1'b0;
    logic [7:0] w_addr = '0, w_wd = '0, w_rd = '0, ea = '0, eb = '0;
    int         na, nb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction at a time: granted at an idle edge, it occupies the
    // memory in the next cycle and completes in the one after that.
    task automatic step();
        bit iss, rsp, ad, bd;
        #1;
        iss = act && cyc == tg;
        rsp = act && cyc == tg + 1;
        ad  = rsp && !w_b && !rst;
        bd  = rsp && w_b && !rst;
        chk("busy", 32'(busy), 32'(iss || rsp));
        chk("mem_state", 32'(mem_state), iss ? 32'd4 : 32'd0);
        chk("mem_op", 32'(mem_op), 32'(iss && w_we));
        chk("mem_addr", 32'(mem_addr), iss ? 32'(w_addr) : 32'd0);
        chk("mem_wdata", 32'(mem_wdata), iss ? 32'(w_wd) : 32'd0);
        chk("a_done", 32'(a_done), 32'(ad));
        chk("b_done", 32'(b_done), 32'(bd));
        chk("a_rdata", 32'(a_rdata), (ad && !w_we) ? 32'(w_rd) : 32'(ea));
        chk("b_rdata", 32'(b_rdata), (bd && !w_we) ? 32'(w_rd) : 32'(eb));
        seen_a = a_done;
        seen_b = b_done;
        if (rst) begin
            act = 1'b0; ea = '0; eb = '0; last_b = 1'b1;
        end else begin
            if (rsp && !w_we) begin
                if (w_b) eb = w_rd; else ea = w_rd;
            end
            if (!iss && !rsp && (a_req || b_req)) begin
`ifdef MEM_ARB_RR_EN
                w_b = (a_req && b_req) ? !last_b : b_req;
`else
                w_b = b_req;
`endif
                w_we   = w_b ? b_we : a_we;
                w_addr = w_b ? b_addr : a_addr;
                w_wd   = w_b ? b_wdata : a_wdata;
                w_rd   = ref_mem[w_addr];
                if (w_we) ref_mem[w_addr] = w_wd;
                act = 1'b1; tg = cyc + 1; last_b = w_b;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_a(input bit r, input bit we, input logic [7:0] ad, input logic [7:0] wd);
        a_req = r; a_we = we; a_addr = ad; a_wdata = wd;
    endtask

    task automatic set_b(input bit r, input bit we, input logic [7:0] ad, input logic [7:0] wd);
        b_req = r; b_we = we; b_addr = ad; b_wdata = wd;
    endtask

    task automatic serve(input bit p, input bit we, input logic [7:0] ad, input logic [7:0] wd);
        int n = 0;
        if (p) set_b(1, we, ad, wd); else set_a(1, we, ad, wd);
        do begin step(); n++; end while (!(p ? seen_b : seen_a) && n < 8);
        chk(p ? "serve_b_latency" : "serve_a_latency", 32'(n), 32'd3);
        if (p) b_req = 1'b0; else a_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] <= 8'(i * 10);
            ref_mem[i] = 8'(i * 10);
        end
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        step();
        // single A read of address 1 holding 8'h0A
        serve(0, 0, 8'h01, 8'h00);
        chk("r035_a_rdata", 32'(a_rdata), 32'h0A);
        chk("r035_b_done", 32'(b_done), 32'd0);
        // B write then read back
        serve(1, 1, 8'h02, 8'h55);
        serve(1, 0, 8'h02, 8'h00);
        chk("r036_b_rdata", 32'(b_rdata), 32'h55);
        chk("r036_a_rdata", 32'(a_rdata), 32'h0A);
        // reset landing in the ISSUE cycle of a write
        set_b(1, 1, 8'h00, 8'hFF);
        step();
        rst = 1'b1; b_req = 1'b0;
        step();
        rst = 1'b0;
        chk("r039_busy", 32'(busy), 32'd0);
        chk("r039_b_done", 32'(b_done), 32'd0);
        step();
        serve(0, 0, 8'h00, 8'h00);
        chk("r039_readback", 32'(a_rdata), 32'hFF);
        // reset landing in the RESP cycle of a read
        set_b(1, 0, 8'h01, 8'h00);
        step();
        step();
        rst = 1'b1; b_req = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("r029_b_rdata", 32'(b_rdata), 32'd0);
        // A pulses during the RESP cycle of a B access
        set_b(1, 0, 8'h03, 8'h00);
        step();
        step();
        set_a(1, 0, 8'h05, 8'h00);
        step();
        a_req = 1'b0; b_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r040_no_a_done", 32'(seen_a), 32'd0);
        end
        // both requesters hold their requests
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_a(1, 0, 8'h04, 8'h00);
        set_b(1, 0, 8'h06, 8'h00);
        na = 0; nb = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            na += int'(seen_a); nb += int'(seen_b);
        end
`ifdef MEM_ARB_RR_EN
        chk("r037_a_count", 32'(na), 32'd2);
        chk("r037_b_count", 32'(nb), 32'd2);
`else
        chk("r038_a_count", 32'(na), 32'd0);
        chk("r038_b_count", 32'(nb), 32'd4);
`endif
        b_req = 1'b0;
        na = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            na += int'(seen_a);
        end
        chk("r038_a_after_b_drop", 32'(na), 32'd1);
        a_req = 1'b0;
        step();
        // random traffic on a small address window with occasional resets
        for (int i = 0; i < 400; i++) begin
            if (a_req && seen_a) a_req = 1'b0;
            else if (!a_req && $urandom_range(0, 2) == 0)
                set_a(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
            if (b_req && seen_b) b_req = 1'b0;
            else if (!b_req && $urandom_range(0, 2) == 0)
                set_b(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 8, address width of the shared data memory.
REQ-002 Parameter DATA_W, 8, data width of the shared data memory.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 a_req / b_req  in  1  requester A (fetch) / B (load-store) request, held high until done.
REQ-007 a_we / b_we  in  1  1 = write, 0 = read; stable while req high.
REQ-008 a_addr / b_addr  in  ADDR_W  word address; stable while req high.
REQ-009 a_wdata / b_wdata  in  DATA_W  store data; stable while req high.
REQ-010 a_rdata / b_rdata  out  DATA_W  read data, valid in the cycle done is high.
REQ-011 a_done / b_done  out  1  one-cycle completion pulse for reads and writes.
REQ-012 mem_state  out  3  memory stage code; 3'd4 (STATE_MEMORY) only during an access, else 3'd0.
REQ-013 mem_op  out  2  2'b00 read, 2'b01 write.
REQ-014 mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address and store data.
REQ-015 mem_rdata  in  DATA_W  memory load value, registered by memory at the access edge.
REQ-016 busy  out  1  high in every state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, RESP.
REQ-018 IDLE: if no req, stay; else pick a winner, latch its we/addr/wdata and port id, go to ISSUE.
REQ-019 ISSUE: mem_state=4, mem_op from latched we, mem_addr/mem_wdata from latch; go to RESP unconditionally.
REQ-020 RESP: mem_state=0; copy mem_rdata to winner's rdata (reads only), pulse winner's done, go to IDLE.
REQ-021 Latency: req sampled high in IDLE at edge t -> done high in cycle t+2; one access per 3 cycles max.
REQ-022 Losing requester's done SHALL stay 0; its request is served next IDLE if still asserted.
REQ-023 rdata SHALL hold its last value between reads; writes SHALL NOT change rdata.
REQ-024 Req dropped before grant is a withdrawal, no access; req dropped after grant does not abort the access.
REQ-025 Both reqs high in IDLE: arbitration per REQ-031/032; exactly one grant per IDLE cycle.
REQ-026 mem_op/mem_addr/mem_wdata SHALL be 0 outside ISSUE.

Reset
REQ-027 rst: state=IDLE, a_done=b_done=0, a_rdata=b_rdata=0, mem_state=0, mem_op=0, mem_addr=0, mem_wdata=0, busy=0, last-grant=B.
REQ-028 rst during ISSUE: memory still acts on that edge (memory unreset); no done pulse is issued.
REQ-029 rst during RESP: pending done is suppressed; rdata cleared to 0.

Configuration
REQ-030 Macro MEM_ARB_RR_EN selects arbitration policy.
REQ-031 Defined: round-robin; on conflict grant the port not granted last; last-grant updates on every grant.
REQ-032 Undefined: fixed priority, B always beats A; last-grant register absent.

Structure
REQ-033 Package mem_arb_pkg SHALL hold STATE_MEMORY (3'd4), MEM_READ (2'b00), MEM_WRITE (2'b01), FSM state encoding.
REQ-034 Sub-module mem_arb_pick (combinational winner select from reqs and last-grant) is natural; FSM stays in mem_arbiter.

Verification
REQ-035 A read only, addr 8'h01, mem[1]=8'h0A -> mem_state=4 in cycle t+1, a_done and a_rdata=8'h0A in t+2, b_done=0.
REQ-036 B write addr 8'h02 data 8'h55, then B read 8'h02 -> second b_rdata=8'h55, a_rdata unchanged.
REQ-037 A and B both request continuously, RR_EN defined -> grants alternate A,B,A,... starting with A after reset; each done every 3 cycles.
REQ-038 Same stimulus, RR_EN undefined -> only B served while b_req high; A served the IDLE after b_req drops.
REQ-039 B write 8'hFF to addr 0, rst asserted in ISSUE cycle -> no b_done, FSM IDLE next cycle, subsequent read of addr 0 returns 8'hFF.
REQ-040 A req pulsed one cycle while FSM in RESP of a B access -> no A access, no a_done, mem_state never 4 for A.
